fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, SHALL be the first fetch address after reset.
REQ-002 Parameter PC_STEP, default 16'd1, SHALL be the word-address increment per fetched instruction.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous and active-low.
REQ-005 imem_req  output  1  instruction-memory request strobe.
REQ-006 imem_addr  output  16  request word address; valid while imem_req=1.
REQ-007 imem_gnt  input  1  memory accepted the request this cycle.
REQ-008 imem_rvalid  input  1  response data valid; at most one per granted request, any cycle after the grant.
REQ-009 imem_rdata  input  16  fetched instruction.
REQ-010 stall  input  1  decode stage cannot accept; hold the IF/ID outputs.
REQ-011 redirect  input  1  taken branch/jump; flush and refetch.
REQ-012 redirect_pc  input  16  new fetch address; sampled when redirect=1.
REQ-013 id_valid  output  1  IF/ID register holds a live instruction.
REQ-014 id_pc  output  16  address of the held instruction.
REQ-015 id_opcode, id_one, id_two, id_three  output  4 each  instr[15:12], [11:8], [7:4], [3:0]; these feed the decode-stage immediate extender.

Function
REQ-016 pc SHALL hold the next request address; on imem_req&&imem_gnt, pc <= pc+PC_STEP (mod 2^16, wraps FFFF->0000) and req_pc <= pc.
REQ-017 FSM SHALL have states REQ, WAIT and DRAIN.
- REQ: imem_req = !skid_full; on grant -> WAIT.
- WAIT: imem_req=0; on rvalid -> REQ.
- DRAIN: imem_req=0; next rvalid is discarded -> REQ.
REQ-018 At most one request SHALL be outstanding.
REQ-019 Accepted response (rvalid in WAIT) SHALL load the IF/ID register next cycle if !id_valid or !stall; otherwise it loads the skid buffer.
REQ-020 While skid_full, when stall=0 the skid contents SHALL move to the IF/ID register and the skid SHALL empty; no new request issues while skid_full.
REQ-021 id_valid SHALL clear on a non-stalled cycle with nothing new to load; IF/ID contents SHALL remain unchanged while stall=1 and id_valid=1.
REQ-022 Load-to-output latency SHALL be one cycle (rvalid at edge N -> id_valid at N+1 when unstalled).
REQ-023 redirect SHALL take priority over stall and over any same-cycle response: next cycle id_valid=0, skid empty, pc=redirect_pc.
REQ-024 redirect in WAIT, or in REQ with a same-cycle grant, SHALL go to DRAIN; redirect in REQ without grant stays in REQ; redirect in DRAIN stays in DRAIN.
REQ-025 A response arriving in the same cycle as redirect while in WAIT SHALL be discarded and SHALL move the FSM to REQ, not DRAIN.

Reset
REQ-026 While rst_n=0: pc=RESET_PC, req_pc=0, state=REQ, skid empty, id_valid=0, id_pc=0, all id fields=0, imem_req=0.
REQ-027 The first request (imem_addr=RESET_PC) SHALL issue in the first cycle after rst_n rises; reset mid-transaction SHALL abandon the outstanding request, and any later rvalid SHALL be ignored, since the FSM is in REQ.

Structure
REQ-028 The FSM state enum, the instruction field bit positions and the instruction width (16) SHALL live in the shared CPU package.
REQ-029 The one-entry holding buffer SHALL be a sub-module fetch_skid (data+pc, full flag, load/unload/clear).

Verification
REQ-030 Reset release, gnt=1, rvalid one cycle after each grant, rdata=16'h8123 -> imem_addr 0000; id_valid=1, id_pc=0000, opcode=8, one=1, two=2, three=3.
REQ-031 Stream of 4 fetches with stall=1 held for 3 cycles after the first output -> id_* frozen on instruction 0; one response captured in skid; no request while skid full; outputs resume in order, none lost.
REQ-032 redirect=1, redirect_pc=16'h0040 while in WAIT -> the following rvalid is discarded; the next imem_addr is 0040; the next id_pc is 0040.
REQ-033 redirect concurrent with rvalid in WAIT -> that instruction is dropped; FSM is in REQ next cycle; the next request addresses redirect_pc.
REQ-034 Start at pc=16'hFFFF -> requests FFFF then 0000.
REQ-035 rst_n pulsed low while in WAIT, rvalid arriving after release -> id_valid stays 0; the first request addresses RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_pkg
//  Description : Shared CPU definitions for the fetch stage: instruction and
//                address widths, instruction field positions, FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

    localparam int c_INSTR_W   = 16;
    localparam int c_ADDR_W    = 16;
    localparam int c_FIELD_W   = 4;

    // Field positions inside a 16-bit instruction word
    localparam int c_OPC_LSB   = 12;
    localparam int c_ONE_LSB   = 8;
    localparam int c_TWO_LSB   = 4;
    localparam int c_THREE_LSB = 0;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_e;

    // Extract one 4-bit field starting at bit position lsb
    function automatic logic [c_FIELD_W-1:0] instr_field(
        input logic [c_INSTR_W-1:0] instr,
        input int                   lsb
    );
        return instr[lsb +: c_FIELD_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_if
//  Description : Instruction-memory request/response bus between the fetch
//                stage (master) and instruction memory (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic                 imem_req;
    logic [c_ADDR_W-1:0]  imem_addr;
    logic                 imem_gnt;
    logic                 imem_rvalid;
    logic [c_INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/fetch_skid.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_skid
//  Description : One-entry holding buffer (instruction + pc) used when a
//                response arrives while decode is stalled.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid
    import fetch_stage_pkg::*;
(
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 load_i,
    input  wire logic                 unload_i,
    input  wire logic                 clear_i,
    input  wire logic [c_INSTR_W-1:0] data_i,
    input  wire logic [c_ADDR_W-1:0]  pc_i,
    output logic                      full_o,
    output logic [c_INSTR_W-1:0]      data_o,
    output logic [c_ADDR_W-1:0]       pc_o
);

    logic                 full_q;
    logic [c_INSTR_W-1:0] data_q;
    logic [c_ADDR_W-1:0]  pc_q;

    // Full flag and payload; clear/unload win over a simultaneous load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
            pc_q   <= '0;
        end else begin
            if (clear_i || unload_i) begin
                full_q <= 1'b0;
            end else if (load_i) begin
                full_q <= 1'b1;
            end
            if (load_i) begin
                data_q <= data_i;
                pc_q   <= pc_i;
            end
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;
    assign pc_o   = pc_q;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch stage: single-outstanding request FSM,
//                IF/ID pipeline register with stall/redirect handling and a
//                one-entry skid buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd1
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    fetch_stage_if.master             imem,
    input  wire logic                 stall,
    input  wire logic                 redirect,
    input  wire logic [c_ADDR_W-1:0]  redirect_pc,
    output logic                      id_valid,
    output logic [c_ADDR_W-1:0]       id_pc,
    output logic [c_FIELD_W-1:0]      id_opcode,
    output logic [c_FIELD_W-1:0]      id_one,
    output logic [c_FIELD_W-1:0]      id_two,
    output logic [c_FIELD_W-1:0]      id_three
);

    fetch_state_e         state_q,    state_d;
    logic [c_ADDR_W-1:0]  pc_q,       pc_d;
    logic [c_ADDR_W-1:0]  req_pc_q,   req_pc_d;
    logic                 id_valid_q, id_valid_d;
    logic [c_ADDR_W-1:0]  id_pc_q,    id_pc_d;
    logic [c_INSTR_W-1:0] id_instr_q, id_instr_d;

    logic                 w_req;
    logic                 w_grant;
    logic                 w_accept;
    logic                 w_skid_full;
    logic                 w_skid_load;
    logic                 w_skid_unload;
    logic                 w_skid_clear;
    logic [c_INSTR_W-1:0] w_skid_data;
    logic [c_ADDR_W-1:0]  w_skid_pc;

    fetch_skid u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (w_skid_load),
        .unload_i (w_skid_unload),
        .clear_i  (w_skid_clear),
        .data_i   (imem.imem_rdata),
        .pc_i     (req_pc_q),
        .full_o   (w_skid_full),
        .data_o   (w_skid_data),
        .pc_o     (w_skid_pc)
    );

    // Request is gated by rst_n so nothing is asked for while reset is held
    assign w_req    = rst_n && (state_q == S_REQ) && !w_skid_full;
    assign w_grant  = w_req && imem.imem_gnt;
    // A same-cycle redirect kills the response arriving in WAIT
    assign w_accept = (state_q == S_WAIT) && imem.imem_rvalid && !redirect;

    // State, pc and IF/ID registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            id_valid_q <= 1'b0;
            id_pc_q    <= '0;
            id_instr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
        end
    end

    // FSM next state: a response always returns to REQ, even with redirect
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ:   if (w_grant) state_d = redirect ? S_DRAIN : S_WAIT;
            S_WAIT: begin
                if (imem.imem_rvalid) state_d = S_REQ;
                else if (redirect)    state_d = S_DRAIN;
            end
            S_DRAIN: if (imem.imem_rvalid) state_d = S_REQ;
            default: state_d = S_REQ;
        endcase
    end

    // Fetch address and in-flight request address
    always_comb begin
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        if (w_grant) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + PC_STEP;
        end
        if (redirect) begin
            pc_d = redirect_pc;
        end
    end

    // IF/ID register and skid control: redirect > skid drain > new response
    always_comb begin
        id_valid_d    = id_valid_q;
        id_pc_d       = id_pc_q;
        id_instr_d    = id_instr_q;
        w_skid_load   = 1'b0;
        w_skid_unload = 1'b0;
        w_skid_clear  = 1'b0;
        if (redirect) begin
            id_valid_d   = 1'b0;
            w_skid_clear = 1'b1;
        end else if (w_skid_full) begin
            if (!stall) begin
                id_valid_d    = 1'b1;
                id_pc_d       = w_skid_pc;
                id_instr_d    = w_skid_data;
                w_skid_unload = 1'b1;
            end
        end else if (w_accept) begin
            if (!id_valid_q || !stall) begin
                id_valid_d = 1'b1;
                id_pc_d    = req_pc_q;
                id_instr_d = imem.imem_rdata;
            end else begin
                w_skid_load = 1'b1;
            end
        end else if (!stall) begin
            id_valid_d = 1'b0;
        end
    end

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = pc_q;

    assign id_valid  = id_valid_q;
    assign id_pc     = id_pc_q;
    assign id_opcode = instr_field(id_instr_q, c_OPC_LSB);
    assign id_one    = instr_field(id_instr_q, c_ONE_LSB);
    assign id_two    = instr_field(id_instr_q, c_TWO_LSB);
    assign id_three  = instr_field(id_instr_q, c_THREE_LSB);

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Self-checking bench for fetch_stage: randomized memory
//                responder, stream-level reference model and scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [15:0] c_RESET_PC = 16'h0000;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        gnt;
    logic        rvalid;
    logic [15:0] rdata;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        id_valid;
    logic [15:0] id_pc;
    logic [3:0]  id_opcode, id_one, id_two, id_three;

    fetch_stage_if bus ();
    assign bus.imem_gnt    = gnt;
    assign bus.imem_rvalid = rvalid;
    assign bus.imem_rdata  = rdata;

    fetch_stage #(.RESET_PC(c_RESET_PC), .PC_STEP(16'd1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (bus.master),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_opcode   (id_opcode),
        .id_one      (id_one),
        .id_two      (id_two),
        .id_three    (id_three)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Knobs for the random driver
    int p_gnt   = 100;
    int p_stall = 0;
    int p_redir = 0;
    int dmax    = 0;

    // Reference model state: next fetch address, in-flight request, and the
    // ordered stream of instructions decode is still owed
    logic [15:0] model_pc = c_RESET_PC;
    logic        o_valid  = 1'b0;
    logic        o_killed = 1'b0;
    logic [15:0] o_addr   = '0;
    int          o_age    = 0;
    int          o_delay  = 0;
    exp_t        exp_q[$];

    function automatic logic [15:0] mem_f(input logic [15:0] a);
        if (a == 16'h0000) return 16'h8123;
        return (a * 16'h2F1B) ^ 16'hC3A5;
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Monitor: compares IF/ID outputs against the head of the expected stream
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
            chk("rst_id_pc", {16'd0, id_pc}, 32'd0);
            chk("rst_id_fields", {16'd0, id_opcode, id_one, id_two, id_three}, 32'd0);
            chk("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
        end else begin
            chk("id_valid", {31'd0, id_valid}, {31'd0, (exp_q.size() > 0)});
            if (exp_q.size() > 0) begin
                chk("id_pc", {16'd0, id_pc}, {16'd0, exp_q[0].pc});
                chk("id_opcode", {28'd0, id_opcode}, {28'd0, exp_q[0].instr[15:12]});
                chk("id_one",    {28'd0, id_one},    {28'd0, exp_q[0].instr[11:8]});
                chk("id_two",    {28'd0, id_two},    {28'd0, exp_q[0].instr[7:4]});
                chk("id_three",  {28'd0, id_three},  {28'd0, exp_q[0].instr[3:0]});
            end
        end
    end

    // Model: checks the request side, then applies the upcoming clock edge
    always @(negedge clk) begin
        logic g;
        logic accept;
        #2;
        if (!rst_n) begin
            exp_q.delete();
            o_valid  = 1'b0;
            o_killed = 1'b0;
            model_pc = c_RESET_PC;
        end else begin
            chk("imem_req", {31'd0, bus.imem_req}, {31'd0, (!o_valid && exp_q.size() < 2)});
            if (bus.imem_req)
                chk("imem_addr", {16'd0, bus.imem_addr}, {16'd0, model_pc});
            g      = bus.imem_req && gnt;
            accept = 1'b0;
            if (rvalid && o_valid) begin
                accept  = !o_killed && !redirect;
                o_valid = 1'b0;
            end else if (o_valid) begin
                o_age++;
            end
            if (redirect) begin
                exp_q.delete();
                o_killed = 1'b1;
            end else begin
                if (exp_q.size() > 0 && !stall) void'(exp_q.pop_front());
                if (accept) exp_q.push_back('{pc: o_addr, instr: rdata});
            end
            if (g) begin
                o_valid  = 1'b1;
                o_killed = redirect;
                o_addr   = model_pc;
                o_age    = 0;
                o_delay  = $urandom_range(0, dmax);
            end
            if (redirect)  model_pc = redirect_pc;
            else if (g)    model_pc = model_pc + 16'd1;
        end
    end

    // One cycle of randomized stimulus, applied just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
        gnt         = ($urandom_range(0, 99) < p_gnt);
        rvalid      = o_valid && (o_age >= o_delay);
        rdata       = rvalid ? mem_f(o_addr) : 16'($urandom);
        stall       = ($urandom_range(0, 99) < p_stall);
        redirect    = ($urandom_range(0, 99) < p_redir);
        redirect_pc = 16'($urandom);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance until a live (not drained) request is outstanding
    task automatic tick_until_wait(input string nm);
        int k;
        k = 0;
        tick();
        while (!(o_valid && !o_killed) && k < 50) begin
            tick();
            k++;
        end
        chk(nm, {31'd0, (o_valid && !o_killed)}, 32'd1);
    endtask

    initial begin
        int k;
        rst_n = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        repeat (3) @(posedge clk);

        // Reset release, always-grant, response one cycle after grant
        tick();
        rst_n = 1'b1;
        ticks(8);

        // Stall for three cycles right after an output appears
        k = 0;
        tick();
        while (exp_q.size() == 0 && k < 50) begin tick(); k++; end
        chk("stall_setup", {31'd0, (exp_q.size() > 0)}, 32'd1);
        stall = 1'b1;
        tick(); stall = 1'b1;
        tick(); stall = 1'b1;
        ticks(10);

        // Redirect while waiting; the pending response must be dropped
        dmax = 2;
        tick_until_wait("redir_wait_setup");
        rvalid = 1'b0; redirect = 1'b1; redirect_pc = 16'h0040;
        ticks(10);

        // Redirect concurrent with the response in WAIT
        tick_until_wait("redir_rvalid_setup");
        rvalid = 1'b1; rdata = mem_f(o_addr);
        redirect = 1'b1; redirect_pc = 16'h1230;
        ticks(10);

        // Address wrap FFFF -> 0000
        dmax = 0;
        tick();
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        ticks(10);

        // Reset while waiting, stale response after release
        dmax = 3;
        tick_until_wait("rst_wait_setup");
        rvalid = 1'b0; rst_n = 1'b0;
        tick(); rvalid = 1'b0;
        tick(); rst_n = 1'b1; gnt = 1'b0; rvalid = 1'b1; rdata = 16'hDEAD;
        tick(); gnt = 1'b0;
        ticks(8);

        // Long randomized run
        p_gnt = 70; p_stall = 30; p_redir = 3; dmax = 3;
        ticks(3000);

        p_stall = 0; p_redir = 0;
        ticks(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
